// File: rtl/neuron_mac_if.sv
// Handshake bundle between the x/weight feeder, the neuron core and the output stage.
// The feeder/output side uses master; the core uses slave.
interface neuron_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] weight;
  logic signed [DATA_W-1:0] bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] y;
  logic signed [ACC_W-1:0]  acc;
  logic                     sat;

  modport master (
    output in_valid, x, weight, bias, out_ready,
    input  in_ready, out_valid, y, acc, sat
  );

  modport slave (
    input  in_valid, x, weight, bias, out_ready,
    output in_ready, out_valid, y, acc, sat
  );
endinterface

// File: rtl/neuron_mac.sv
// Multi-input neuron core: accumulates N_INPUTS signed x*weight beats, adds a bias,
// applies optional ReLU and saturates the result to DATA_W.
module neuron_mac #(
  parameter int DATA_W   = 8,
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 20,
  parameter bit RELU_EN  = 1'b1
) (
  input logic         clk,
  input logic         rst,
  neuron_mac_if.slave bus
);
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN    = ~Y_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_HOLD} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc_sum;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_bias;
  logic signed [DATA_W-1:0] r_y;
  logic                     r_out_valid;
  logic                     r_sat;

  logic                       w_in_ready;
  logic                       w_accept;
  logic                       w_release;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_relu;
  logic signed [ACC_W-1:0]    w_clip;

  // Full-precision product; ACC_W is sized so the running sum can never wrap.
  assign w_prod     = (2*DATA_W)'(bus.x) * (2*DATA_W)'(bus.weight);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = r_acc_sum + ACC_W'(r_bias);
  assign w_relu     = (RELU_EN && w_sum[ACC_W-1]) ? '0 : w_sum;
  assign w_clip     = (w_relu > Y_MAX) ? Y_MAX : ((w_relu < Y_MIN) ? Y_MIN : w_relu);

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_release = (r_state == S_HOLD) && bus.out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can infer a latch.
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = (N_INPUTS == 1) ? S_FINISH : S_ACCUM;
      end
      S_ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (r_cnt == LAST_CNT)) w_next = S_FINISH;
      end
      S_FINISH: w_next = S_HOLD;
      S_HOLD:   if (bus.out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_acc_sum   <= '0;
      r_bias      <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_state == S_IDLE) begin
          r_acc_sum <= w_prod_ext;
          r_bias    <= bus.bias;
          r_cnt     <= CNT_W'(1);
        end else begin
          r_acc_sum <= r_acc_sum + w_prod_ext;
          r_cnt     <= r_cnt + CNT_W'(1);
        end
      end
      if (r_state == S_FINISH) begin
        r_acc       <= w_sum;
        r_y         <= w_clip[DATA_W-1:0];
        r_sat       <= (w_relu != w_clip);
        r_out_valid <= 1'b1;
      end
      // y/acc/sat deliberately keep their last values after the result is taken.
      if (w_release) begin
        r_out_valid <= 1'b0;
        r_acc_sum   <= '0;
        r_cnt       <= '0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.acc       = r_acc;
  assign bus.sat       = r_sat;
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
Parametrised multi-input neuron core. It streams N_INPUTS signed (x, weight) pairs over a valid/ready handshake and accumulates their products in a wide accumulator. It then adds a signed bias, optionally applies ReLU, and saturates the result to DATA_W. It sits between the input/weight feeder and the activation/output stage, and replaces the single-product accumulate cell.

Parameters:
DATA_W, 8, width of x, weight, bias and y (all signed two's complement)
N_INPUTS, 4, number of (x, weight) beats per neuron evaluation (>=1)
ACC_W, 20, accumulator width; must be >= 2*DATA_W + clog2(N_INPUTS) + 1
RELU_EN, 1, 1 = clamp negative results to 0 before saturation; 0 = linear output

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
in_valid  in  1  x/weight beat valid
in_ready  out  1  core accepts a beat this cycle
x  in  DATA_W  signed input activation
weight  in  DATA_W  signed weight
bias  in  DATA_W  signed bias; sampled on the first accepted beat of an evaluation
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
y  out  DATA_W  signed result after ReLU and saturation
acc  out  ACC_W  full-precision sum(x*w)+bias, before ReLU and saturation
sat  out  1  y was clipped to its min or max

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, beat counter=0, accumulator=0, bias register=0. Outputs: out_valid=0, y=0, acc=0, sat=0. in_ready=1 once rst=1.
- States: IDLE, ACCUM, FINISH, HOLD.
- IDLE: in_ready=1. A beat is accepted when in_valid & in_ready at a rising edge. On acceptance, the accumulator loads sext(x*w), the bias register loads bias, and count=1. Next state is FINISH if N_INPUTS==1, else ACCUM.
- ACCUM: in_ready=1. Each accepted beat does acc_reg += sext(x*w) and count++. The beat that makes count==N_INPUTS moves the core to FINISH. While in_valid=0, nothing changes; bubbles are allowed.
- FINISH (one cycle): in_ready=0. At the edge, compute s = acc_reg + sext(bias_reg).
  - acc <= s.
  - r = (RELU_EN && s<0) ? 0 : s.
  - y <= clip(r, -2^(DATA_W-1), 2^(DATA_W-1)-1).
  - sat <= (r != y).
  - out_valid <= 1; next state is HOLD.
- HOLD: in_ready=0. out_valid, y, acc and sat stay stable until out_valid & out_ready at an edge. At that edge: out_valid <= 0, accumulator and counter cleared, state returns to IDLE. y/acc/sat keep their last values; they are only meaningful while out_valid=1.
- Latency: out_valid rises on the first edge after the edge accepting the last beat. Minimum throughput is one evaluation per N_INPUTS+2 cycles with out_ready held 1.
- x and weight are ignored when no beat is accepted. bias is ignored except on the first beat.
- Arithmetic: product is 2*DATA_W signed, sign-extended to ACC_W. ACC_W sizing guarantees no accumulator wrap-around, so overflow handling lives only in the final clip.
- ReLU is applied before the clip. With RELU_EN=1, sat can only indicate positive clipping.
- Reset mid-evaluation (any state) aborts immediately. Partial sums are discarded and no out_valid is produced for the aborted evaluation.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. N_INPUTS=4, RELU_EN=1. Send four beats x=5, w=2, with bias=1 on beat 1, out_ready=1. Required: out_valid one cycle after the 4th beat, acc=41, y=41, sat=0, in_ready back to 1 the following cycle.
2. Saturation: four beats x=127, w=127, bias=127. Required: acc=64643, y=127, sat=1. Repeat with x=-128, w=127, bias=-128 and RELU_EN=0. Required: acc=-65152, y=-128, sat=1.
3. ReLU: x=-5, w=3 x4, bias=-2. With RELU_EN=1 required: acc=-62, y=0, sat=0. With RELU_EN=0 required: y=-62, sat=0.
4. Handshake stress: random in_valid bubbles between beats, then out_ready held 0 for 3 cycles after out_valid. Required: result same as scenario 1, y/acc stable while held, in_ready=0 throughout FINISH/HOLD, beats offered during HOLD not consumed.
5. Reset mid-op: accept 2 beats, pulse rst=0 asynchronously between edges. Required: out_valid, y, acc, sat all 0 immediately. A following full evaluation (scenario 1 stimulus) gives 41 with no residue from the aborted sums.
6. Back-to-back: two evaluations (41, then x=1, w=1 x4 with bias=0 giving 4) with out_ready=1 and in_valid held high. Required: second result 4, and no beat is lost or double-counted across the boundary.
